// File: rtl/mac_array_gen.sv
`default_nettype none
// ==========================================================================
// mac_array_gen: ROW x COL weight-stationary systolic MAC array.
// Define MAC_ARRAY_PSUM_SAT_EN to clamp execute sums instead of wrapping.
// Revision: 1.0 - initial release
// ==========================================================================
module mac_array_gen #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROW*BW-1:0]      in_w,
    input  logic [1:0]             inst_w,
    input  logic [PSUM_BW*COL-1:0] in_n,
    output logic [PSUM_BW*COL-1:0] out_s,
    output logic [COL-1:0]         valid,
    output logic                   idle
);

    localparam logic [1:0] c_inst_nop  = 2'b00;
    localparam logic [1:0] c_inst_load = 2'b01;
    localparam logic [1:0] c_inst_exec = 2'b10;
    localparam logic [1:0] c_inst_clr  = 2'b11;

`ifdef MAC_ARRAY_PSUM_SAT_EN
    localparam int c_sum_w = PSUM_BW + 2*BW + 2;
    localparam logic signed [c_sum_w-1:0] c_sum_max =
        {{(c_sum_w-PSUM_BW+1){1'b0}}, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [c_sum_w-1:0] c_sum_min =
        {{(c_sum_w-PSUM_BW+1){1'b1}}, {(PSUM_BW-1){1'b0}}};
`else
    localparam int c_sum_w = PSUM_BW;
`endif

    localparam int                 c_cnt_w   = $clog2(ROW+COL+1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(ROW+COL);

    logic [1:0]                skew_q [ROW];
    logic [1:0]                w_inst [ROW][COL+1];
    logic [BW-1:0]             w_data [ROW][COL+1];
    logic signed [PSUM_BW-1:0] w_psum [ROW+1][COL];
    logic [c_cnt_w-1:0]        idle_cnt_q, idle_cnt_d;

    // Row r sees inst_w after r+1 registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROW; i++) skew_q[i] <= c_inst_nop;
        end else begin
            skew_q[0] <= inst_w;
            for (int i = 1; i < ROW; i++) skew_q[i] <= skew_q[i-1];
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_north
        assign w_psum[0][c] = in_n[PSUM_BW*c +: PSUM_BW];
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row
        assign w_inst[r][0] = skew_q[r];
        assign w_data[r][0] = in_w[BW*r +: BW];

        for (genvar c = 0; c < COL; c++) begin : g_col
            logic [1:0]                inst_q, inst_d;
            logic [BW-1:0]             data_q, weight_q, weight_d;
            logic                      loaded_q, loaded_d;
            logic signed [PSUM_BW-1:0] psum_q, psum_d, w_exec;
            logic signed [c_sum_w-1:0] w_act, w_wt, w_sum;

            always_comb begin
                w_act = c_sum_w'($signed({1'b0, w_data[r][c]}));
                w_wt  = loaded_q ? c_sum_w'($signed(weight_q)) : '0;
                w_sum = c_sum_w'(w_psum[r][c]) + w_act * w_wt;
`ifdef MAC_ARRAY_PSUM_SAT_EN
                if (w_sum > c_sum_max)      w_exec = c_sum_max[PSUM_BW-1:0];
                else if (w_sum < c_sum_min) w_exec = c_sum_min[PSUM_BW-1:0];
                else                        w_exec = w_sum[PSUM_BW-1:0];
`else
                w_exec = w_sum[PSUM_BW-1:0];
`endif
            end

            always_comb begin
                inst_d   = w_inst[r][c];
                weight_d = weight_q;
                loaded_d = loaded_q;
                psum_d   = w_psum[r][c];
                case (w_inst[r][c])
                    // An empty PE absorbs the word and leaves a bubble behind
                    c_inst_load: begin
                        if (!loaded_q) begin
                            weight_d = w_data[r][c];
                            loaded_d = 1'b1;
                            inst_d   = c_inst_nop;
                        end
                    end
                    c_inst_exec: psum_d = w_exec;
                    c_inst_clr: begin
                        weight_d = '0;
                        loaded_d = 1'b0;
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    inst_q   <= c_inst_nop;
                    data_q   <= '0;
                    weight_q <= '0;
                    loaded_q <= 1'b0;
                    psum_q   <= '0;
                end else begin
                    inst_q   <= inst_d;
                    data_q   <= w_data[r][c];
                    weight_q <= weight_d;
                    loaded_q <= loaded_d;
                    psum_q   <= psum_d;
                end
            end

            assign w_inst[r][c+1] = inst_q;
            assign w_data[r][c+1] = data_q;
            assign w_psum[r+1][c] = psum_q;
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_south
        assign out_s[PSUM_BW*c +: PSUM_BW] = w_psum[ROW][c];
        assign valid[c] = (w_inst[ROW-1][c+1] == c_inst_exec);
    end

    // Counts quiet cycles since the last non-nop, saturating at ROW+COL
    always_comb begin
        if (inst_w != c_inst_nop)        idle_cnt_d = '0;
        else if (idle_cnt_q != c_cnt_max) idle_cnt_d = idle_cnt_q + 1'b1;
        else                              idle_cnt_d = idle_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) idle_cnt_q <= c_cnt_max;
        else       idle_cnt_q <= idle_cnt_d;
    end

    assign idle = (idle_cnt_q == c_cnt_max);

endmodule
`default_nettype wire

// File: tb/tb_mac_array_gen.sv
`default_nettype none
// ==========================================================================
// tb_mac_array_gen: randomized + directed bench for mac_array_gen (8x8,
// 2x2 and 1x1/PSUM_BW=8 instances). Revision: 1.0 - initial release
// ==========================================================================
module tb_mac_array_gen;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int NCYC    = 700;
    localparam int NRAND   = -999999;
    localparam int PMAX    = (1 << (PSUM_BW-1)) - 1;
    localparam int PMIN    = -(1 << (PSUM_BW-1));
`ifdef MAC_ARRAY_PSUM_SAT_EN
    localparam int OVF_EXP = 127;
`else
    localparam int OVF_EXP = -51;
`endif

    logic                   clk;
    logic                   rst_m;
    logic [ROW*BW-1:0]      in_w_m;
    logic [1:0]             inst_m;
    logic [PSUM_BW*COL-1:0] in_n_m;
    logic [PSUM_BW*COL-1:0] out_s_m;
    logic [COL-1:0]         valid_m;
    logic                   idle_m;

    logic        rst_s;
    logic [7:0]  in_w_s2;
    logic [1:0]  inst_s2;
    logic [31:0] in_n_s2;
    logic [31:0] out_s_s2;
    logic [1:0]  valid_s2;
    logic        idle_s2;
    logic [3:0]  in_w_s1;
    logic [1:0]  inst_s1;
    logic [7:0]  in_n_s1;
    logic [7:0]  out_s_s1;
    logic [0:0]  valid_s1;
    logic        idle_s1;

    mac_array_gen #(.BW(BW), .PSUM_BW(PSUM_BW), .ROW(ROW), .COL(COL)) u_dut (
        .clk(clk), .reset(rst_m), .in_w(in_w_m), .inst_w(inst_m), .in_n(in_n_m),
        .out_s(out_s_m), .valid(valid_m), .idle(idle_m)
    );

    mac_array_gen #(.BW(4), .PSUM_BW(16), .ROW(2), .COL(2)) u_dut_2x2 (
        .clk(clk), .reset(rst_s), .in_w(in_w_s2), .inst_w(inst_s2), .in_n(in_n_s2),
        .out_s(out_s_s2), .valid(valid_s2), .idle(idle_s2)
    );

    mac_array_gen #(.BW(4), .PSUM_BW(8), .ROW(1), .COL(1)) u_dut_1x1 (
        .clk(clk), .reset(rst_s), .in_w(in_w_s1), .inst_w(inst_s1), .in_n(in_n_s1),
        .out_s(out_s_s1), .valid(valid_s1), .idle(idle_s1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec;
    int n_bad;
    int cur_cyc;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cur_cyc, obs, want);
        end
    endtask

    // Program: per issue cycle an instruction, reset flag, lane words and north psums
    int prog_inst [NCYC];
    bit prog_rst  [NCYC];
    int prog_a    [NCYC][ROW];
    int prog_n    [NCYC][COL];
    int np;

    bit exp_vld  [NCYC+32][COL];
    int exp_sum  [NCYC+32][COL];
    bit exp_idle [NCYC];

    int wgt [ROW][COL];
    bit ld  [ROW][COL];

    function automatic int rnd_psum();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int sx(input int x);
        return (x >= (1 << (BW-1))) ? x - (1 << BW) : x;
    endfunction

    function automatic int acc(input int s, input int p);
        int t;
        t = s + p;
`ifdef MAC_ARRAY_PSUM_SAT_EN
        if (t > PMAX) t = PMAX;
        if (t < PMIN) t = PMIN;
`else
        t = t & ((1 << PSUM_BW) - 1);
        if (t > PMAX) t = t - (1 << PSUM_BW);
`endif
        return t;
    endfunction

    task automatic emit(input int inst, input bit rst, input int a_val, input int n_val);
        prog_inst[np] = inst;
        prog_rst[np]  = rst;
        for (int r = 0; r < ROW; r++)
            prog_a[np][r] = (a_val < 0) ? int'($urandom_range(0, (1 << BW) - 1)) : a_val;
        for (int c = 0; c < COL; c++)
            prog_n[np][c] = (n_val == NRAND) ? rnd_psum() : n_val;
        np++;
    endtask

    task automatic build_program();
        np = 0;
        repeat (2) emit(0, 1'b1, 0, 0);
        repeat (6) emit(0, 1'b0, 0, 0);
        emit(2, 1'b0, -1, NRAND);
        repeat (20) emit(0, 1'b0, -1, NRAND);
        repeat (COL) emit(1, 1'b0, -1, NRAND);
        emit(2, 1'b0, -1, NRAND);
        repeat (20) emit(0, 1'b0, -1, NRAND);
        emit(3, 1'b0, -1, NRAND);
        emit(2, 1'b0, 7, 100);
        repeat (20) emit(0, 1'b0, -1, NRAND);
        repeat (COL) emit(1, 1'b0, -1, NRAND);
        emit(2, 1'b0, -1, NRAND);
        repeat (20) emit(0, 1'b0, -1, NRAND);
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            emit((sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3, 1'b0, -1, NRAND);
        end
        repeat (20) emit(0, 1'b0, -1, NRAND);
        repeat (COL) emit(1, 1'b0, -1, NRAND);
        emit(2, 1'b0, -1, NRAND);
        emit(0, 1'b0, -1, NRAND);
        repeat (2) emit(0, 1'b1, 0, 0);
        repeat (5) emit(0, 1'b0, -1, NRAND);
        emit(2, 1'b0, -1, NRAND);
        repeat (25) emit(0, 1'b0, -1, NRAND);
    endtask

    // Instructions take effect in issue order in every PE, so a sequential walk suffices
    task automatic run_model();
        int  last_busy;
        bit  busy_seen;
        last_busy = 0;
        busy_seen = 1'b0;
        for (int j = 0; j < NCYC+32; j++)
            for (int c = 0; c < COL; c++) begin
                exp_vld[j][c] = 1'b0;
                exp_sum[j][c] = 0;
            end
        for (int k = 0; k < np; k++) begin
            exp_idle[k] = !busy_seen || (k - last_busy > ROW + COL);
            if (prog_rst[k]) begin
                for (int r = 0; r < ROW; r++)
                    for (int c = 0; c < COL; c++) begin
                        wgt[r][c] = 0;
                        ld[r][c]  = 1'b0;
                    end
                for (int j = k + 1; j < NCYC+32; j++)
                    for (int c = 0; c < COL; c++) exp_vld[j][c] = 1'b0;
                busy_seen = 1'b0;
            end else begin
                if (prog_inst[k] != 0) begin
                    busy_seen = 1'b1;
                    last_busy = k;
                end
                case (prog_inst[k])
                    1: for (int r = 0; r < ROW; r++) begin
                        bit done;
                        done = 1'b0;
                        for (int c = 0; c < COL; c++)
                            if (!done && !ld[r][c]) begin
                                wgt[r][c] = sx(prog_a[k][r]);
                                ld[r][c]  = 1'b1;
                                done      = 1'b1;
                            end
                    end
                    2: for (int c = 0; c < COL; c++) begin
                        int s;
                        s = prog_n[k][c];
                        for (int r = 0; r < ROW; r++)
                            s = acc(s, prog_a[k][r] * (ld[r][c] ? wgt[r][c] : 0));
                        exp_vld[k+ROW+1+c][c] = 1'b1;
                        exp_sum[k+ROW+1+c][c] = s;
                    end
                    3: for (int r = 0; r < ROW; r++)
                        for (int c = 0; c < COL; c++) begin
                            wgt[r][c] = 0;
                            ld[r][c]  = 1'b0;
                        end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        logic [COL-1:0]            ev;
        logic signed [PSUM_BW-1:0] col;
        int                        j;
        n_vec   = 0;
        n_bad   = 0;
        cur_cyc = 0;
        rst_m   = 1'b1;
        inst_m  = 2'b00;
        in_w_m  = '0;
        in_n_m  = '0;
        rst_s   = 1'b1;
        inst_s2 = 2'b00;
        in_w_s2 = '0;
        in_n_s2 = '0;
        inst_s1 = 2'b00;
        in_w_s1 = '0;
        in_n_s1 = '0;

        build_program();
        run_model();

        for (int k = 0; k < np; k++) begin
            @(posedge clk);
            #1;
            rst_m  = prog_rst[k];
            inst_m = prog_rst[k] ? 2'b00 : 2'(prog_inst[k]);
            for (int r = 0; r < ROW; r++) begin
                j = k - r - 1;
                in_w_m[BW*r +: BW] = (j >= 0) ? BW'(prog_a[j][r]) : '0;
            end
            for (int c = 0; c < COL; c++) begin
                j = k - 1 - c;
                in_n_m[PSUM_BW*c +: PSUM_BW] = (j >= 0) ? PSUM_BW'(prog_n[j][c]) : '0;
            end
            @(negedge clk);
            cur_cyc = k;
            if (k >= 1) begin
                for (int c = 0; c < COL; c++) ev[c] = exp_vld[k][c];
                chk("valid", valid_m, ev);
                chk("idle", idle_m, exp_idle[k]);
                for (int c = 0; c < COL; c++)
                    if (exp_vld[k][c]) begin
                        col = out_s_m[PSUM_BW*c +: PSUM_BW];
                        chk("out_s", col, exp_sum[k][c]);
                    end
                if (k <= 6) chk("out_s_after_reset", out_s_m, 0);
            end
        end

        // Directed worked examples on the 2x2 and the 8-bit 1x1 arrays
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
            j       = i - 2;
            rst_s   = (i < 2);
            inst_m  = 2'b00;
            inst_s2 = (j == 0 || j == 1) ? 2'b01 : (j == 2) ? 2'b10 : 2'b00;
            in_w_s2[3:0] = (j == 1) ? 4'd3 : (j == 2) ? 4'hE : (j == 3) ? 4'd5 : 4'd0;
            in_w_s2[7:4] = (j == 2) ? 4'd1 : (j == 3) ? 4'd4 : (j == 4) ? 4'd2 : 4'd0;
            inst_s1 = (j == 0) ? 2'b01 : (j == 1) ? 2'b10 : 2'b00;
            in_w_s1 = (j == 1) ? 4'd7 : (j == 2) ? 4'd15 : 4'd0;
            in_n_s1 = (j == 2) ? 8'd100 : 8'd0;
            @(negedge clk);
            cur_cyc = i;
            if (i >= 2) begin
                chk("valid_2x2", valid_s2, (j == 5) ? 2'b01 : (j == 6) ? 2'b10 : 2'b00);
                chk("valid_1x1", valid_s1, (j == 3) ? 1'b1 : 1'b0);
                if (j == 0) chk("idle_2x2_reset", idle_s2, 1);
                if (j == 5) chk("col0_2x2", $signed(out_s_s2[15:0]), 17);
                if (j == 6) chk("col1_2x2", $signed(out_s_s2[31:16]), -2);
                if (j == 3) chk("ovf_1x1", $signed(out_s_s1), OVF_EXP);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
